// File: rtl/rvc_pkg.sv
// Shared constants and state type for the rvc ready/valid controller.
// Optional accept counter is enabled with RVC_ACCEPT_CNT_EN.
package rvc_pkg;
    localparam int RVC_WIDTH = 8;
    localparam int RVC_CNT_W = 16;

    // S_EMPTY: ready asserted; S_FULL: held word presented downstream.
    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } rvc_state_e;
endpackage

// File: rtl/rvc_flag_reg.sv
// 1-bit enable register with synchronous reset value 1; holds the ready flag.
module rvc_flag_reg (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);

    // Flag storage: forced to 1 on reset, otherwise loads d when enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b1;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/rvc_ready_ctrl.sv
// Single-entry ready/valid controller with a 1-deep holding buffer.
// Define RVC_ACCEPT_CNT_EN to add the accept_cnt output and its counter.
module rvc_ready_ctrl
    import rvc_pkg::*;
#(
    parameter int WIDTH = RVC_WIDTH
`ifdef RVC_ACCEPT_CNT_EN
    ,
    parameter int CNT_W = RVC_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             ready_reg,
    output logic             ready_en
`ifdef RVC_ACCEPT_CNT_EN
    ,
    output logic [CNT_W-1:0] accept_cnt
`endif
);

    rvc_state_e       state_r;
    rvc_state_e       state_nxt_s;
    logic             ready_s;
    logic             accept_s;
    logic             drain_s;
    logic             ready_reg_s;
    logic             ready_en_s;
    logic [WIDTH-1:0] out_data_r;

    // Handshake decode and next value/enable for the ready flag
    always_comb begin
        accept_s   = valid & ready_s;
        drain_s    = (state_r == S_FULL) & out_ready;
        ready_en_s = rst | accept_s | drain_s;
        if (rst) begin
            ready_reg_s = 1'b1;
        end else if (accept_s) begin
            ready_reg_s = 1'b0;
        end else if (drain_s) begin
            ready_reg_s = 1'b1;
        end else begin
            ready_reg_s = ready_s;
        end
    end

    rvc_flag_reg u_ready_flag (
        .clk (clk),
        .rst (rst),
        .en  (ready_en_s),
        .d   (ready_reg_s),
        .q   (ready_s)
    );

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_EMPTY: begin
                if (accept_s) begin
                    state_nxt_s = S_FULL;
                end else begin
                    state_nxt_s = S_EMPTY;
                end
            end
            S_FULL: begin
                if (drain_s) begin
                    state_nxt_s = S_EMPTY;
                end else begin
                    state_nxt_s = S_FULL;
                end
            end
            default: state_nxt_s = S_EMPTY;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Holding buffer: captured on accept, kept through drain
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            out_data_r <= data_in;
        end else begin
            out_data_r <= out_data_r;
        end
    end

`ifdef RVC_ACCEPT_CNT_EN
    logic [CNT_W-1:0] accept_cnt_r;

    // Accepted-word counter, wraps naturally at full scale
    always_ff @(posedge clk) begin
        if (rst) begin
            accept_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            accept_cnt_r <= accept_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            accept_cnt_r <= accept_cnt_r;
        end
    end

    assign accept_cnt = accept_cnt_r;
`endif

    assign ready     = ready_s;
    assign out_valid = (state_r == S_FULL);
    assign out_data  = out_data_r;
    assign ready_reg = ready_reg_s;
    assign ready_en  = ready_en_s;

endmodule

// File: tb/tb_rvc_ready_ctrl.sv
// Self-checking bench for rvc_ready_ctrl: directed scenarios plus random traffic
// against a queue-based model of a one-slot buffer.
module tb_rvc_ready_ctrl;

    logic       clk;
    logic       rst;
    logic       valid;
    logic [7:0] data_in;
    logic       ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       ready_reg;
    logic       ready_en;
`ifdef RVC_ACCEPT_CNT_EN
    logic [15:0] accept_cnt;
`endif

    rvc_ready_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .data_in   (data_in),
        .ready     (ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .ready_reg (ready_reg),
        .ready_en  (ready_en)
`ifdef RVC_ACCEPT_CNT_EN
        ,
        .accept_cnt(accept_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the buffer is a queue holding at most one word
    bit [7:0] held[$];
    bit [7:0] m_data;
    int       m_cnt;
    bit       model_ok = 1'b0;
    logic     mirror;

    always @(posedge clk) begin
        mirror <= ready_en ? ready_reg : mirror;
        if (rst) begin
            held.delete();
            m_data   = 8'h00;
            m_cnt    = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (valid && held.size() == 0) begin
                held.push_back(data_in);
                m_data = data_in;
                m_cnt  = (m_cnt + 1) % 65536;
            end else if (held.size() == 1 && out_ready) begin
                void'(held.pop_front());
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (model_ok) begin
            bit m_ready, m_acc, m_drn, m_en, m_rreg;
            m_ready = (held.size() == 0);
            m_acc   = valid && m_ready;
            m_drn   = !m_ready && out_ready;
            m_en    = rst || m_acc || m_drn;
            m_rreg  = rst ? 1'b1 : (m_acc ? 1'b0 : (m_drn ? 1'b1 : m_ready));
            chk("ready",     {31'd0, ready},     {31'd0, m_ready});
            chk("out_valid", {31'd0, out_valid}, {31'd0, !m_ready});
            chk("out_data",  {24'd0, out_data},  {24'd0, m_data});
            chk("ready_en",  {31'd0, ready_en},  {31'd0, m_en});
            chk("ready_reg", {31'd0, ready_reg}, {31'd0, m_rreg});
            chk("mirror",    {31'd0, mirror},    {31'd0, m_ready});
`ifdef RVC_ACCEPT_CNT_EN
            chk("accept_cnt", {16'd0, accept_cnt}, m_cnt);
`endif
        end
    end

    // Apply inputs just after an edge, then wait through the next edge
    task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic o);
        rst = r; valid = v; data_in = d; out_ready = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; data_in = 8'h00; out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("t1_ready",     {31'd0, ready},     32'd1);
        chk("t1_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_mirror",    {31'd0, mirror},    32'd1);
        rst = 1'b0;
        #1;
        chk("t2_ready_en_idle", {31'd0, ready_en}, 32'd0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("t2_ready", {31'd0, ready}, 32'd1);

        cyc(1'b0, 1'b1, 8'hA5, 1'b0);
        chk("t3_ready",     {31'd0, ready},     32'd0);
        chk("t3_out_valid", {31'd0, out_valid}, 32'd1);
        chk("t3_out_data",  {24'd0, out_data},  32'h0000_00A5);
`ifdef RVC_ACCEPT_CNT_EN
        chk("t3_accept_cnt", {16'd0, accept_cnt}, 32'd1);
`endif

        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 8'h3C, 1'b0);
            chk("t4_out_data", {24'd0, out_data}, 32'h0000_00A5);
            chk("t4_ready",    {31'd0, ready},    32'd0);
        end

        cyc(1'b0, 1'b1, 8'h3C, 1'b1);
        chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_ready",     {31'd0, ready},     32'd1);
        chk("t5_data_kept", {24'd0, out_data},  32'h0000_00A5);
        cyc(1'b0, 1'b1, 8'h3C, 1'b0);
        chk("t5_out_data",  {24'd0, out_data},  32'h0000_003C);
        chk("t5_valid2",    {31'd0, out_valid}, 32'd1);

        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk("t6_ready",     {31'd0, ready},     32'd1);
        chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_out_data",  {24'd0, out_data},  32'd0);
`ifdef RVC_ACCEPT_CNT_EN
        chk("t6_accept_cnt", {16'd0, accept_cnt}, 32'd0);
`endif

        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0,
                8'($urandom_range(0, 255)),
                $urandom_range(0, 2) != 0 ? 1'b1 : 1'b0);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
